// File: rtl/ber_scan_pkg.sv
// Shared state encoding and constants for the BER phase-scan sequencer.
// The optional per-phase error log (BER_SCAN_RESULT_LOG_EN) uses sat_err32.
package ber_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_SYNC    = 3'd2,
        ST_MEASURE = 3'd3,
        ST_EVAL    = 3'd4,
        ST_APPLY   = 3'd5,
        ST_DONE    = 3'd6
    } scan_state_t;

    localparam int N_PHASES = 4;
    localparam logic [31:0] ERR_SAT = 32'hFFFF_FFFF;

    // Clamp an error sum into a 32-bit log field; failed phases log as saturated.
    function automatic logic [31:0] sat_err32(input logic [127:0] sum, input logic failed);
        if (failed || (sum[127:32] != 96'd0)) begin
            sat_err32 = ERR_SAT;
        end else begin
            sat_err32 = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/ber_symbol_timer.sv
// Symbol-strobe counter with synchronous clear and terminal-count compare.
// o_hit flags the strobe that completes i_limit strobes since the last clear.
module ber_symbol_timer #(
    parameter int NB_TIMER = 16
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_valid,
    input  logic [NB_TIMER-1:0] i_limit,
    output logic                o_hit
);

    logic [NB_TIMER-1:0] count_r;

    // Strobe counter; saturates so a long idle period never wraps into a false hit.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            count_r <= {NB_TIMER{1'b0}};
        end else if (i_clear) begin
            count_r <= {NB_TIMER{1'b0}};
        end else if (i_valid && (count_r != {NB_TIMER{1'b1}})) begin
            count_r <= count_r + {{(NB_TIMER-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign o_hit = i_valid && (count_r == (i_limit - {{(NB_TIMER-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/ber_phase_scan_ctrl.sv
// Scans the four downsampling phases, measures I+Q BER on each and applies the best.
// Define BER_SCAN_RESULT_LOG_EN to keep a saturated per-phase error log on o_phase_errors.
module ber_phase_scan_ctrl
    import ber_scan_pkg::*;
#(
    parameter int NB_CNT         = 64,
    parameter int NB_TIMER       = 16,
    parameter int SETTLE_SYMBOLS = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int WINDOW_BITS    = 1024
) (
    input  logic                    clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_start,
    input  logic                    i_valid,
    input  logic                    i_lock_i,
    input  logic                    i_lock_q,
    input  logic [NB_CNT-1:0]       i_errors_i,
    input  logic [NB_CNT-1:0]       i_errors_q,
    input  logic [NB_CNT-1:0]       i_bits_i,
    output logic [1:0]              o_phase_sel,
    output logic                    o_ber_en,
    output logic                    o_ber_clr_n,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_fail,
    output logic [1:0]              o_best_phase,
    output logic [NB_CNT:0]         o_min_errors,
    output logic [N_PHASES*32-1:0]  o_phase_errors
);

    scan_state_t         state_r, state_next;
    logic                timer_hit_s, timer_clr_s, timeout_s, start_ok_s, ber_on_s;
    logic [NB_TIMER-1:0] timer_limit_s;
    logic [NB_CNT:0]     sum_s, min_r;
    logic                better_s, any_lock_eval_s;
    logic [1:0]          best_eval_s, phase_idx_r, phase_sel_r, best_r;
    logic                failed_r, any_lock_r, busy_r, done_r, fail_r, ber_en_r, clr_n_r;

    assign timer_limit_s = (state_r == ST_SYNC) ? NB_TIMER'(LOCK_TIMEOUT) : NB_TIMER'(SETTLE_SYMBOLS);
    assign timer_clr_s   = (state_next != state_r);

    ber_symbol_timer #(.NB_TIMER(NB_TIMER)) u_timer (
        .clock   (clock),
        .i_reset (i_reset),
        .i_clear (timer_clr_s),
        .i_valid (i_valid),
        .i_limit (timer_limit_s),
        .o_hit   (timer_hit_s)
    );

    // Next-state logic; dropping i_enable overrides everything.
    always_comb begin
        state_next = state_r;
        timeout_s  = 1'b0;
        if (!i_enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (i_start) state_next = ST_SETTLE;
                    else         state_next = state_r;
                end
                ST_SETTLE: begin
                    if (timer_hit_s) state_next = ST_SYNC;
                    else             state_next = ST_SETTLE;
                end
                ST_SYNC: begin
                    if (i_lock_i && i_lock_q) begin
                        state_next = ST_MEASURE;
                    end else if (timer_hit_s) begin
                        state_next = ST_EVAL;
                        timeout_s  = 1'b1;
                    end else begin
                        state_next = ST_SYNC;
                    end
                end
                ST_MEASURE: begin
                    if (i_bits_i >= NB_CNT'(WINDOW_BITS)) state_next = ST_EVAL;
                    else                                  state_next = ST_MEASURE;
                end
                ST_EVAL: begin
                    if (phase_idx_r == 2'd3) state_next = ST_APPLY;
                    else                     state_next = ST_SETTLE;
                end
                ST_APPLY: begin
                    if (timer_hit_s) state_next = ST_DONE;
                    else             state_next = ST_APPLY;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign start_ok_s = i_enable && i_start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign ber_on_s   = (state_next == ST_SYNC) || (state_next == ST_MEASURE) ||
                        (state_next == ST_EVAL) || (state_next == ST_DONE);

    // Sum is one bit wider than the counters so it can never overflow.
    assign sum_s           = {1'b0, i_errors_i} + {1'b0, i_errors_q};
    assign better_s        = !failed_r && (sum_s < min_r);
    assign best_eval_s     = better_s ? phase_idx_r : best_r;
    assign any_lock_eval_s = any_lock_r || !failed_r;

    // State register, registered control outputs and scan bookkeeping.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            ber_en_r    <= 1'b0;
            clr_n_r     <= 1'b0;
            phase_idx_r <= 2'd0;
            phase_sel_r <= 2'd0;
            best_r      <= 2'd0;
            min_r       <= {(NB_CNT+1){1'b1}};
            failed_r    <= 1'b0;
            any_lock_r  <= 1'b0;
        end else begin
            state_r  <= state_next;
            busy_r   <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            done_r   <= (state_next == ST_DONE);
            ber_en_r <= ber_on_s;
            clr_n_r  <= ber_on_s;
            if (!i_enable) begin
                fail_r <= 1'b0;
            end else if (start_ok_s) begin
                phase_idx_r <= 2'd0;
                phase_sel_r <= 2'd0;
                min_r       <= {(NB_CNT+1){1'b1}};
                fail_r      <= 1'b0;
                failed_r    <= 1'b0;
                any_lock_r  <= 1'b0;
            end else if (timeout_s) begin
                failed_r <= 1'b1;
            end else if (state_r == ST_EVAL) begin
                if (better_s) min_r <= sum_s;
                any_lock_r <= any_lock_eval_s;
                failed_r   <= 1'b0;
                if (phase_idx_r == 2'd3) begin
                    // With no locked phase the slicer falls back to phase 0.
                    best_r      <= any_lock_eval_s ? best_eval_s : 2'd0;
                    phase_sel_r <= any_lock_eval_s ? best_eval_s : 2'd0;
                    fail_r      <= !any_lock_eval_s;
                end else begin
                    best_r      <= best_eval_s;
                    phase_idx_r <= phase_idx_r + 2'd1;
                    phase_sel_r <= phase_idx_r + 2'd1;
                end
            end
        end
    end

    assign o_phase_sel  = phase_sel_r;
    assign o_ber_en     = ber_en_r;
    assign o_ber_clr_n  = clr_n_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_fail       = fail_r;
    assign o_best_phase = best_r;
    assign o_min_errors = min_r;

`ifdef BER_SCAN_RESULT_LOG_EN
    logic [N_PHASES*32-1:0] log_r;

    // Per-phase error log, written once per phase in EVAL.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            log_r <= {(N_PHASES*32){1'b0}};
        end else if (start_ok_s) begin
            log_r <= {(N_PHASES*32){1'b0}};
        end else if (i_enable && (state_r == ST_EVAL)) begin
            log_r[32*phase_idx_r +: 32] <= sat_err32(128'(sum_s), failed_r);
        end else begin
            log_r <= log_r;
        end
    end

    assign o_phase_errors = log_r;
`else
    assign o_phase_errors = {(N_PHASES*32){1'b0}};
`endif

endmodule

// File: doc/ber_phase_scan_ctrl.md
Name: ber_phase_scan_ctrl

Overview:
Sequencer that automatically finds the best downsampling phase for the TX/BER loop. It steps the phase selector through all four values, clears and enables the I/Q BER counters for each phase, and measures errors over a fixed bit window. It then applies the phase with the fewest combined I+Q errors. It sits beside the top-level TX block and replaces the manual phase switches and BER-enable switch.

Parameters:
NB_CNT, 64, width of error/bit counter inputs
NB_TIMER, 16, width of the internal symbol timer
SETTLE_SYMBOLS, 16, valid strobes to wait after a phase change (BER cleared)
LOCK_TIMEOUT, 4096, valid strobes allowed for I and Q sync before the phase is declared failed
WINDOW_BITS, 1024, bits (i_bits_i) counted per phase measurement

Ports:
clock  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_enable  in  1  scan controller enable; low forces IDLE
i_start  in  1  single-cycle scan request
i_valid  in  1  symbol strobe (same strobe that feeds PRBS/FIR)
i_lock_i  in  1  I BER counter sync flag
i_lock_q  in  1  Q BER counter sync flag
i_errors_i  in  NB_CNT  I error count
i_errors_q  in  NB_CNT  Q error count
i_bits_i  in  NB_CNT  I bits-compared count
o_phase_sel  out  2  phase selector to slicer
o_ber_en  out  1  BER counter enable
o_ber_clr_n  out  1  active-low BER counter clear
o_busy  out  1  scan in progress
o_done  out  1  scan finished, best phase applied
o_fail  out  1  no phase achieved lock
o_best_phase  out  2  chosen phase
o_min_errors  out  NB_CNT+1  I+Q errors of the chosen phase
o_phase_errors  out  4*32  per-phase error log (see Optional Feature)

Behaviour:
- Reset (async, i_reset=0): state IDLE; o_phase_sel=0, o_ber_en=0, o_ber_clr_n=0, o_busy=0, o_done=0, o_fail=0, o_best_phase=0, o_min_errors=all ones, o_phase_errors=0.
- All outputs are registered. Timers count i_valid strobes only.
- States: IDLE, SETTLE, SYNC, MEASURE, EVAL, APPLY, DONE.
- IDLE: o_ber_clr_n=0, o_ber_en=0. On i_start=1 with i_enable=1: phase index=0, o_min_errors=all ones, o_done=0, o_fail=0, then go to SETTLE.
- SETTLE: o_phase_sel=phase index, o_ber_clr_n=0, o_ber_en=0. After SETTLE_SYMBOLS strobes go to SYNC, with the timer cleared.
- SYNC: o_ber_clr_n=1, o_ber_en=1.
  - i_lock_i & i_lock_q both 1 → MEASURE.
  - Timer reaches LOCK_TIMEOUT → EVAL, with the phase marked failed (errors treated as all ones).
- MEASURE: when i_bits_i >= WINDOW_BITS → EVAL. If lock drops during MEASURE, the measurement continues; the BER counters own resync.
- EVAL (1 cycle):
  - sum = i_errors_i + i_errors_q, computed at NB_CNT+1 bits with no overflow.
  - If the phase is not failed and sum < o_min_errors (strict), update o_min_errors and o_best_phase. Ties keep the lower phase index.
  - If phase index == 3 go to APPLY; else increment the index and go to SETTLE.
- APPLY: o_phase_sel=o_best_phase, o_ber_clr_n=0 for SETTLE_SYMBOLS strobes, then go to DONE. If no phase locked: o_fail=1, o_best_phase=0.
- DONE: o_done=1, o_busy=0, o_ber_clr_n=1, o_ber_en=1 (continuous BER on the chosen phase). A new i_start restarts the scan from the phase 0 SETTLE.
- o_busy=1 in every state other than IDLE and DONE.
- i_start while busy: ignored.
- i_enable=0 in any state: synchronous return to IDLE next cycle. o_done and o_fail are cleared; o_best_phase and o_min_errors are held.
- i_valid absent: the FSM stalls in timer states (no hidden timeout on clock cycles).

Optional Feature:
- Macro BER_SCAN_RESULT_LOG_EN.
- Defined: in EVAL, o_phase_errors[32*k+:32] captures the sum for phase k, saturated to 32'hFFFF_FFFF; failed phases log 32'hFFFF_FFFF. Registers clear on i_start.
- Undefined: o_phase_errors is tied to 0 and no log registers are synthesized.

Decomposition:
- Shared package ber_scan_pkg holds:
  - state encoding constants (3-bit, IDLE=0 … DONE=6)
  - N_PHASES=4
  - the error saturation constant
- Natural sub-module: ber_symbol_timer, a valid-strobe counter with clear and a terminal-count compare, instanced once and reused across SETTLE, SYNC and APPLY.

Test Plan:
- Reset mid-MEASURE (i_reset low for 1 cycle) → all outputs return to reset values immediately, with no clock edge needed.
- Errors per phase {40,3,3,90}, locks immediate, WINDOW_BITS=1024 → o_best_phase=1 (tie with phase 2 keeps the lower index), o_min_errors=3, o_done=1, o_phase_sel=1.
- Phase 0 never locks, others return errors {-,10,5,7} → phase 0 takes LOCK_TIMEOUT=4096 strobes in SYNC; o_best_phase=2, o_min_errors=5.
- No phase locks → o_fail=1, o_best_phase=0, o_done=1 after 4×(16+4096)+16 strobes.
- i_start pulsed during SYNC of phase 1 → ignored, scan completes normally. i_enable dropped during phase 2 → IDLE next cycle, o_busy=0, o_ber_en=0.
- With BER_SCAN_RESULT_LOG_EN, phase 3 sum 2^33 → o_phase_errors[127:96]=32'hFFFF_FFFF. Without the macro → o_phase_errors=0 throughout.
